// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver: shadow capture, hex decode,
// per-digit dp/blank, leading-zero suppression, dwell/gap scan FSM, registered pins.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GAP_CYCLES = 2,
  parameter int AN_ACT_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       data_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  input  logic                          lz_en,
  output logic [7:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  typedef enum logic {
    DRIVE = 1'b0,
    GAP   = 1'b1
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [4*NUM_DIGITS-1:0] data_sh;
  logic [NUM_DIGITS-1:0]   dp_sh, blank_sh;
  logic [NUM_DIGITS-1:0]   lz_sup;
  logic                    nz_seen;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  // A digit is a leading zero only while nothing above it (nibble or dp) is significant.
  always_comb begin
    lz_sup  = '0;
    nz_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      nz_seen   = nz_seen | (data_sh[4*k +: 4] != 4'h0) | dp_sh[k];
      lz_sup[k] = ~nz_seen;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    case (state)
      DRIVE: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          cnt_n   = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = DRIVE;
          idx_n   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = DRIVE;
      end
    endcase
  end

  always_comb begin
    nib    = data_sh[4*idx +: 4];
    onehot = NUM_DIGITS'(1) << idx;
    seg_n  = 8'hFF;
    an_n   = AN_OFF;
    if (state == DRIVE) begin
      an_n = (AN_ACT_LOW != 0) ? ~onehot : onehot;
      // Dark digits keep their anode slot so the scan timing never shifts.
      if (!(blank_sh[idx] || (lz_en && lz_sup[idx])))
        seg_n = {~dp_sh[idx], hex_decode(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DRIVE;
      cnt       <= '0;
      idx       <= '0;
      data_sh   <= '0;
      dp_sh     <= '0;
      blank_sh  <= '0;
      seg       <= 8'hFF;
      an        <= AN_OFF;
      digit_idx <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      seg       <= seg_n;
      an        <= an_n;
      digit_idx <= idx;
      if (load) begin
        data_sh  <= data_in;
        dp_sh    <= dp_in;
        blank_sh <= blank_in;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, dwell 4, gap 1): a cycle-level
// reference model feeds an expected-pin queue, plus constant checks of decoded digits.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int G  = 1;
  localparam int SLOT  = SD + G;
  localparam int FRAME = N * SLOT;

  logic          clk;
  logic          rst;
  logic          load;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic          lz_en;
  logic [7:0]    seg;
  logic [3:0]    an;
  logic [1:0]    digit_idx;

  int checks = 0;
  int errors = 0;

  // Expected pins packed as {seg, an, digit_idx}.
  logic [13:0] exp_q[$];

  int          ph;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [7:0]  cap[N];

  logic [6:0] dec_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .GAP_CYCLES (G),
    .AN_ACT_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .lz_en     (lz_en),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] model_pins();
    int   slot;
    int   dig;
    logic dark;
    logic [3:0] nb;
    logic [7:0] s;
    slot = ph % SLOT;
    dig  = (ph / SLOT) % N;
    if (slot >= SD) return {8'hFF, 4'hF, 2'(dig)};
    nb   = 4'((m_data >> (4 * dig)) & 16'hF);
    dark = m_blank[dig] ||
           (lz_en && dig > 0 && (m_data >> (4 * dig)) == 16'd0 && (m_dp >> dig) == 4'd0);
    s    = dark ? 8'hFF : {~m_dp[dig], dec_tab[nb]};
    return {s, ~(4'b0001 << dig), 2'(dig)};
  endfunction

  task automatic step();
    logic [13:0] e;
    if (rst) e = {8'hFF, 4'hF, 2'd0};
    else     e = model_pins();
    exp_q.push_back(e);
    if (rst) begin
      ph = 0; m_data = '0; m_dp = '0; m_blank = '0;
    end else begin
      ph++;
      if (load) begin
        m_data = data_in; m_dp = dp_in; m_blank = blank_in;
      end
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb_seg", seg, e[13:6]);
    chk("sb_an", {4'h0, an}, {4'h0, e[5:2]});
    chk("sb_idx", {6'h0, digit_idx}, {6'h0, e[1:0]});
    for (int k = 0; k < N; k++)
      if (an === ~(4'b0001 << k)) cap[k] = seg;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_cap();
    for (int k = 0; k < N; k++) cap[k] = 8'hxx;
  endtask

  task automatic align_to(input int target);
    int guard;
    guard = 0;
    while ((ph % FRAME) != target && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    chk("align_bound", 8'(guard < 2 * FRAME), 8'd1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
    ph = 0; m_data = '0; m_dp = '0; m_blank = '0;
    clear_cap();

    // Reset held, then released: digit 0 ("0") appears one cycle later.
    run(3);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", {4'h0, an}, 8'h0F);
    rst = 1'b0;
    step();
    chk("first_an", {4'h0, an}, 8'h0E);
    chk("first_seg", seg, 8'hC0);
    run(FRAME + 4);

    // Plain hex word.
    data_in = 16'h12AF; load = 1'b1;
    step();
    load = 1'b0;
    run(FRAME);
    clear_cap();
    run(FRAME);
    chk("hex_d0", cap[0], 8'h8E);
    chk("hex_d1", cap[1], 8'h88);
    chk("hex_d2", cap[2], 8'hA4);
    chk("hex_d3", cap[3], 8'hF9);

    // Leading-zero suppression on and off.
    data_in = 16'h0050; lz_en = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    run(FRAME);
    clear_cap();
    run(FRAME);
    chk("lz_d3", cap[3], 8'hFF);
    chk("lz_d2", cap[2], 8'hFF);
    chk("lz_d1", cap[1], 8'h92);
    chk("lz_d0", cap[0], 8'hC0);
    lz_en = 1'b0;
    run(FRAME);
    clear_cap();
    run(FRAME);
    chk("nolz_d3", cap[3], 8'hC0);
    chk("nolz_d2", cap[2], 8'hC0);

    // dp stops suppression above it; blank beats dp.
    lz_en = 1'b1;
    data_in = 16'h0000; dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    run(FRAME);
    clear_cap();
    run(FRAME);
    chk("lzdp_d3", cap[3], 8'hFF);
    chk("lzdp_d2", cap[2], 8'h40);
    chk("lzdp_d1", cap[1], 8'hC0);
    lz_en = 1'b0;

    data_in = 16'h8888; dp_in = 4'b0100; blank_in = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;
    run(FRAME);
    clear_cap();
    run(FRAME);
    chk("dp_d2", cap[2], 8'h00);
    chk("blank_d0", cap[0], 8'hFF);
    chk("dp_d1", cap[1], 8'h80);
    chk("dp_d3", cap[3], 8'h80);

    // Load landing in the middle of digit 1's dwell: only its last drive cycle changes.
    align_to(SLOT + SD - 2);
    data_in = 16'h8838; load = 1'b1;
    step();
    load = 1'b0;
    chk("midload_old", seg, 8'h80);
    step();
    chk("midload_new", seg, 8'hB0);
    chk("midload_an", {4'h0, an}, 8'h0D);
    step();
    chk("midload_gap", seg, 8'hFF);
    run(FRAME);

    // Reset in the middle of digit 2's dwell.
    align_to(2 * SLOT + 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_an", {4'h0, an}, 8'h0F);
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_idx", {6'h0, digit_idx}, 8'h00);
    step();
    chk("restart_an", {4'h0, an}, 8'h0E);
    chk("restart_seg", seg, 8'hC0);
    run(FRAME);

    // Random loads under the model.
    for (int i = 0; i < 40; i++) begin
      data_in  = 16'($urandom_range(0, 65535));
      dp_in    = 4'($urandom_range(0, 15));
      blank_in = 4'($urandom_range(0, 15));
      lz_en    = 1'($urandom_range(0, 1));
      load     = 1'($urandom_range(0, 1));
      run($urandom_range(1, 7));
    end
    load = 1'b0;
    run(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
